addsub_seq8: RTL and testbench
==============================

ADDSUB_SEQ8 -- requirements
Module: addsub_seq8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; WIDTH SHALL be an even number of at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand request.
REQ-006 SHALL have port a  input  WIDTH  minuend/addend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend/addend.
REQ-008 SHALL have port sub  input  1  1 = a-b, 0 = a+b.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out; for subtract, 1 = no borrow (a >= b unsigned).
REQ-013 SHALL have port ovf  output  1  signed overflow; present only under OVF_FLAG_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid, SHALL latch a, b XOR {WIDTH{sub}}, carry=sub, group index=0, then go to RUN.
REQ-016 RUN: each cycle SHALL compute one 2-bit group from group p/g and the running carry, write 2 sum bits LSB-first, update the running carry, and increment the group index.
REQ-017 SHALL leave RUN for DONE after WIDTH/2 RUN cycles; out_valid SHALL rise exactly WIDTH/2+1 cycles after the accepting edge (5 for WIDTH=8).
REQ-018 DONE: out_valid=1; sum/cout/ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 DONE with out_ready=1 SHALL return to IDLE on that edge; there SHALL be no back-to-back acceptance in that same cycle (in_ready=0 in RUN and DONE).
REQ-020 in_valid, a, b, sub SHALL be ignored outside IDLE; a change after acceptance SHALL not affect the result.
REQ-021 cout SHALL equal the carry out of the MSB group; ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 The group carry equations SHALL be c0 = g0 | p0&cin and c1 = g1 | p1&g0 | p1&p0&cin, with p = a^b' and g = a&b'.

Reset
REQ-023 On rst=1 at a clock edge, SHALL enter IDLE regardless of state and discard any in-flight operation.
REQ-024 Reset values SHALL be: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
REQ-025 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-026 Macro OVF_FLAG_EN defined: the ovf port and its tracking register SHALL exist per REQ-021.
REQ-027 OVF_FLAG_EN undefined: the ovf port and its register SHALL be absent; all other behaviour and latency SHALL be unchanged.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant GROUP_BITS=2.
REQ-029 The 2-bit carry logic of REQ-022 SHALL be a combinational sub-module carry_group2 (inputs p0, p1, g0, g1, cin; outputs c0, c1), instantiated once.

Verification
REQ-030 Add: a=0x3C, b=0x45, sub=0 -> sum=0x81, cout=0, ovf=1, out_valid 5 cycles after acceptance.
REQ-031 Subtract with borrow: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0.
REQ-032 Wrap and signed edge: 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum, cout held; in_ready=0 throughout; in_valid pulses ignored.
REQ-034 Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0; the next request 0x10+0x20 -> sum=0x30.
REQ-035 Build the bench with and without OVF_FLAG_EN -> identical sum/cout/latency results in both builds.

Source files
------------

// File: rtl/addsub_seq8_pkg.sv
// Shared definitions for the serial 2-bit-group adder/subtractor.
// Holds the controller state encoding and the number of bits resolved per step.
package addsub_seq8_pkg;

    // Number of result bits produced per RUN cycle.
    localparam int GROUP_BITS = 2;

    // Controller states: waiting for operands, stepping groups, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/addsub_seq8_carry_group2.sv
// Two-bit carry-lookahead cell used by addsub_seq8.
// Takes per-bit propagate/generate and the incoming carry, and returns the
// carry out of bit 0 (c0) and the carry out of bit 1 (c1).
import addsub_seq8_pkg::*;

module carry_group2 (
    input  logic p0,
    input  logic p1,
    input  logic g0,
    input  logic g1,
    input  logic cin,
    output logic c0,
    output logic c1
);

    // Flat lookahead equations so c1 does not ripple through c0.
    always_comb begin
        c0 = g0 | (p0 & cin);
        c1 = g1 | (p1 & g0) | (p1 & p0 & cin);
    end

endmodule

// File: rtl/addsub_seq8.sv
// Sequential adder/subtractor resolving GROUP_BITS result bits per cycle.
// Handshake: in_valid/in_ready to accept operands, out_valid/out_ready to hand
// off the result. out_valid rises WIDTH/2+1 cycles after the accepting edge.
// WIDTH must be even and at least 2.
// Optional feature: define OVF_FLAG_EN to add the signed-overflow port ovf.
import addsub_seq8_pkg::*;

module addsub_seq8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_GROUPS = WIDTH / GROUP_BITS;
    localparam int IDX_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);

    // Control state
    state_e                state_r;
    logic                  in_ready_r;
    logic                  out_valid_r;

    // Working operands: shifted right one group per RUN cycle so the active
    // group always sits in the low GROUP_BITS bits.
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic                  carry_r;
    logic [IDX_W-1:0]      idx_r;
    logic [WIDTH-1:0]      sum_work_r;

    // Registered result outputs
    logic [WIDTH-1:0]      sum_r;
    logic                  cout_r;
`ifdef OVF_FLAG_EN
    logic                  ovf_work_r;
    logic                  ovf_r;
`endif

    // Group datapath
    logic [GROUP_BITS-1:0] p_s;
    logic [GROUP_BITS-1:0] g_s;
    logic                  c0_s;
    logic                  c1_s;
    logic [GROUP_BITS-1:0] grp_sum_s;
    logic [WIDTH-1:0]      sum_shift_s;
    logic                  last_grp_s;

    // Propagate/generate of the active group, its sum bits and last-group flag.
    always_comb begin
        p_s        = a_r[GROUP_BITS-1:0] ^ b_r[GROUP_BITS-1:0];
        g_s        = a_r[GROUP_BITS-1:0] & b_r[GROUP_BITS-1:0];
        grp_sum_s  = {p_s[1] ^ c0_s, p_s[0] ^ carry_r};
        last_grp_s = (idx_r == LAST_IDX);
    end

    carry_group2 u_carry_group2 (
        .p0  (p_s[0]),
        .p1  (p_s[1]),
        .g0  (g_s[0]),
        .g1  (g_s[1]),
        .cin (carry_r),
        .c0  (c0_s),
        .c1  (c1_s)
    );

    // New group bits enter at the top; after the last group the word is in place.
    if (WIDTH > GROUP_BITS) begin : g_wide
        assign sum_shift_s = {grp_sum_s, sum_work_r[WIDTH-1:GROUP_BITS]};
    end else begin : g_narrow
        assign sum_shift_s = grp_sum_s;
    end

    // Controller: state sequencing and the two handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                RUN: begin
                    if (last_grp_s) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; out_ready is
                    // honoured only once out_valid is visible.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch operands on acceptance, then resolve one group per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            sum_work_r <= {WIDTH{1'b0}};
`ifdef OVF_FLAG_EN
            ovf_work_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert b and seed carry with sub.
                        a_r        <= a;
                        b_r        <= b ^ {WIDTH{sub}};
                        carry_r    <= sub;
                        idx_r      <= {IDX_W{1'b0}};
                        sum_work_r <= {WIDTH{1'b0}};
                    end else begin
                        idx_r      <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    a_r        <= a_r >> GROUP_BITS;
                    b_r        <= b_r >> GROUP_BITS;
                    carry_r    <= c1_s;
                    idx_r      <= idx_r + IDX_W'(1);
                    sum_work_r <= sum_shift_s;
`ifdef OVF_FLAG_EN
                    // Carry into MSB vs carry out of MSB; the last group's value sticks.
                    ovf_work_r <= c0_s ^ c1_s;
`endif
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    // Result registers: loaded once on entry to DONE and held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_r  <= 1'b0;
`endif
        end else if ((state_r == DONE) && !out_valid_r) begin
            sum_r  <= sum_work_r;
            cout_r <= carry_r;
`ifdef OVF_FLAG_EN
            ovf_r  <= ovf_work_r;
`endif
        end else begin
            sum_r  <= sum_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef OVF_FLAG_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_addsub_seq8.sv
// Directed self-checking bench for addsub_seq8 (WIDTH=8).
// Builds with or without OVF_FLAG_EN; ovf is checked only when the port exists.
module tb_addsub_seq8;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef OVF_FLAG_EN
    logic         ovf;
`endif

    int n_assert;
    int n_fail;

    addsub_seq8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge, then scramble them to prove they are not re-sampled.
    task automatic accept_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic sv);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        sub      = sv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = 8'h5A;
        sub      = ~sv;
    endtask

    // Count cycles from the accepting edge to out_valid; expected latency is 5.
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd5);
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                                input logic eo);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef OVF_FLAG_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) begin
            check({tag, "_ovf_x"}, 32'd0, 32'd1);
        end else begin
            n_assert = n_assert + 0;
        end
`endif
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [W-1:0] es, input logic ec, input logic eo);
        accept_op(tag, av, bv, sv);
        wait_result(tag);
        check_result(tag, es, ec, eo);
        release_result(tag);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        sub       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic vectors: a, b, sub -> sum, cout, ovf
        run_op("add_3c_45", 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("sub_00_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_96_69", 8'h96, 8'h69, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Backpressure: hold the result for 10 cycles while in_valid toggles
        accept_op("bp", 8'hAA, 8'h55, 1'b1);
        wait_result("bp");
        check_result("bp", 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a        = 8'h11 + 8'(i);
            b        = 8'h22;
            sub      = 1'b0;
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            check_result("bp_hold", 8'h55, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Reset on the second RUN cycle discards the operation
        accept_op("mid_rst", 8'h3C, 8'h45, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_result("mid_rst", 8'h00, 1'b0, 1'b0);
        run_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
